// File: rtl/serial_pattern_matcher_if.sv
// Bus bundle for serial_pattern_matcher: serial bit stream, pattern load/control
// inputs and the match/count/armed status outputs.
interface serial_pattern_matcher_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    logic             data_in;
    logic             input_valid;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             load_pattern;
    logic             overlap_en;
    logic             count_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output data_in, input_valid, pattern, mask, load_pattern, overlap_en, count_clr,
        input  match, match_count, armed
    );

    modport slave (
        input  data_in, input_valid, pattern, mask, load_pattern, overlap_en, count_clr,
        output match, match_count, armed
    );
endinterface

// File: rtl/serial_pattern_matcher.sv
// Serial pattern matcher: masked compare of a valid-qualified bit stream against a
// loadable pattern, with overlap control and a saturating match counter.
module serial_pattern_matcher #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_pattern_matcher_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  shift_reg;
    logic [PAT_W-1:0]  next_shift;
    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  mask_reg;
    logic [FILL_W-1:0] fill_cnt;
    logic [FILL_W-1:0] fill_nxt;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_nxt;
    logic              match_reg;
    logic              hit;

    // hit looks at the window including the bit being sampled this cycle
    always_comb begin
        next_shift = {shift_reg[PAT_W-2:0], bus.data_in};
        hit        = bus.input_valid
                     && (fill_cnt >= FILL_W'(PAT_W - 1))
                     && (((next_shift ^ pat_reg) & mask_reg) == '0);

        fill_nxt = fill_cnt;
        if (bus.input_valid) begin
            if (hit && !bus.overlap_en) begin
                fill_nxt = '0;
            end else if (fill_cnt != FILL_W'(PAT_W)) begin
                fill_nxt = fill_cnt + FILL_W'(1);
            end
        end

        count_nxt = count_reg;
        if (bus.count_clr) begin
            count_nxt = '0;
        end else if (hit && (count_reg != '1)) begin
            count_nxt = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            fill_cnt  <= '0;
            pat_reg   <= '0;
            mask_reg  <= '1;
            match_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            if (bus.input_valid) begin
                shift_reg <= next_shift;
            end
            fill_cnt  <= fill_nxt;
            match_reg <= hit;
            count_reg <= count_nxt;
            // same-cycle compare above already used the old pattern/mask
            if (bus.load_pattern) begin
                pat_reg  <= bus.pattern;
                mask_reg <= bus.mask;
            end
        end
    end

    assign bus.match       = match_reg;
    assign bus.match_count = count_reg;
    assign bus.armed       = (fill_cnt == FILL_W'(PAT_W));
endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Directed bench for serial_pattern_matcher: three instances (4/8, 8/8, 4/2 bits)
// with a scoreboard queue of expected match pulses.
module tb_serial_pattern_matcher;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic sb_q[$];

    always #5 clk = ~clk;

    serial_pattern_matcher_if #(.PAT_W(4), .CNT_W(8)) b4 ();
    serial_pattern_matcher_if #(.PAT_W(8), .CNT_W(8)) b8 ();
    serial_pattern_matcher_if #(.PAT_W(4), .CNT_W(2)) bc ();

    serial_pattern_matcher #(.PAT_W(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    serial_pattern_matcher #(.PAT_W(8), .CNT_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_pattern_matcher #(.PAT_W(4), .CNT_W(2)) uc (.clk(clk), .rst(rst), .bus(bc.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_match(input int sel);
        case (sel)
            0:       return {31'd0, b4.match};
            1:       return {31'd0, b8.match};
            default: return {31'd0, bc.match};
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int sel);
        case (sel)
            0:       return {24'd0, b4.match_count};
            1:       return {24'd0, b8.match_count};
            default: return {30'd0, bc.match_count};
        endcase
    endfunction

    function automatic logic [31:0] get_armed(input int sel);
        case (sel)
            0:       return {31'd0, b4.armed};
            1:       return {31'd0, b8.armed};
            default: return {31'd0, bc.armed};
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic d, input logic ld, input logic clr);
        case (sel)
            0: begin b4.input_valid = v; b4.data_in = d; b4.load_pattern = ld; b4.count_clr = clr; end
            1: begin b8.input_valid = v; b8.data_in = d; b8.load_pattern = ld; b8.count_clr = clr; end
            default: begin bc.input_valid = v; bc.data_in = d; bc.load_pattern = ld; bc.count_clr = clr; end
        endcase
    endtask

    // one clock: drive at negedge, push expected, compare match 1ns after the edge
    task automatic step(input int sel, input logic v, input logic d, input logic ld,
                        input logic clr, input logic exp_m);
        logic e;
        @(negedge clk);
        drive(sel, v, d, ld, clr);
        sb_q.push_back(exp_m);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("match_d%0d", sel), get_match(sel), {31'd0, e});
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // bits sent MSB first; exp bit i is the expected match after the same bit
    task automatic run(input int sel, input logic [15:0] bits, input int n, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(sel, 1'b1, bits[i], 1'b0, 1'b0, exp[i]);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);
        b4.pattern = '0; b4.mask = '0; b4.overlap_en = 1'b0;
        b8.pattern = '0; b8.mask = '0; b8.overlap_en = 1'b0;
        bc.pattern = '0; bc.mask = '0; bc.overlap_en = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_match_d%0d", s), get_match(s), 32'd0);
            chk($sformatf("rst_count_d%0d", s), get_cnt(s), 32'd0);
            chk($sformatf("rst_armed_d%0d", s), get_armed(s), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // T5: CNT_W=2, reset pattern 0000/mask 1111, continuous zeros
        bc.overlap_en = 1'b1;
        run(2, 16'b0000_0000, 8, 16'b0001_1111);
        chk("t5_armed", get_armed(2), 32'd1);
        chk("t5_count_sat", get_cnt(2), 32'd3);
        step(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_with_hit", get_cnt(2), 32'd0);
        step(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_count_after_clr", get_cnt(2), 32'd1);

        // T4: PAT_W=8, non-overlapping, mid-stream load of 1011xxxx
        b8.overlap_en = 1'b0;
        run(1, 16'b101, 3, 16'b0);
        chk("t4_armed_early", get_armed(1), 32'd0);
        b8.pattern = 8'b1011_0000;
        b8.mask    = 8'b1111_0000;
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(1, 16'b1_0101, 5, 16'b0_0001);
        chk("t4_count", get_cnt(1), 32'd1);
        chk("t4_armed_after_hit", get_armed(1), 32'd0);
        run(1, 16'b101_1000, 7, 16'b0);
        b8.pattern = 8'h00;
        b8.mask    = 8'hFF;
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_old_pattern_count", get_cnt(1), 32'd2);
        run(1, 16'b0000_0000, 8, 16'b0000_0001);
        chk("t4_new_pattern_count", get_cnt(1), 32'd3);

        // T1: PAT_W=4, pattern 1010, overlapping
        b4.overlap_en = 1'b1;
        b4.pattern = 4'b1010;
        b4.mask    = 4'b1111;
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(0, 16'b101, 3, 16'b0);
        chk("t1_armed_3bits", get_armed(0), 32'd0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_armed_4bits", get_armed(0), 32'd1);
        run(0, 16'b10, 2, 16'b01);
        chk("t1_count", get_cnt(0), 32'd2);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_clr", get_cnt(0), 32'd0);

        // T2: pattern 1000
        b4.pattern = 4'b1000;
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(0, 16'b100_0100_0011, 11, 16'b000_1000_1000);
        chk("t2_count", get_cnt(0), 32'd2);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // T3 overlapping
        b4.pattern = 4'b1010;
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(0, 16'b10_1010_1010, 10, 16'b00_0101_0101);
        chk("t3_ovl_count", get_cnt(0), 32'd4);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // T3 non-overlapping, from a clean start
        b4.overlap_en = 1'b0;
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(0, 16'b10_1010_1010, 10, 16'b00_0100_0100);
        chk("t3_novl_count", get_cnt(0), 32'd2);
        chk("t3_novl_armed", get_armed(0), 32'd0);

        // T6: async reset mid-stream, then fresh fill against the reset pattern
        run(0, 16'b111, 3, 16'b0);
        chk("t6_armed_before", get_armed(0), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_match", get_match(0), 32'd0);
        chk("t6_rst_count", get_cnt(0), 32'd0);
        chk("t6_rst_armed", get_armed(0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        b4.overlap_en = 1'b1;
        run(0, 16'b0000, 4, 16'b0001);
        chk("t6_count_after", get_cnt(0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
